// File: rtl/gen_consumer_if.sv
// Bundle of the command, generator-facing and downstream signals of gen_consumer.
//
// Handshake rules: a transfer happens on a rising clock edge where both
// valid and ready are high. gen_valid/gen_output/gen_done are offered by the
// generator and may change only after a transfer or while gen_ready is low.
// out_valid/out_data stay stable until out_ready takes them. gen_done only
// counts on an edge where gen_ready is high.
interface gen_consumer_if #(
    parameter int WIDTH = 32
);
    logic                    cmd_start;
    logic signed [WIDTH-1:0] cmd_arg;
    logic                    cmd_busy;
    logic                    gen_start;
    logic signed [WIDTH-1:0] gen_arg;
    logic                    gen_ready;
    logic                    gen_valid;
    logic signed [WIDTH-1:0] gen_output;
    logic                    gen_done;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_ready;
    logic [15:0]             run_count;
    logic                    run_done;
    logic [1:0]              dbg_state;

    // Environment side: issues commands, plays the generator, consumes output.
    modport master (
        output cmd_start, cmd_arg, gen_valid, gen_output, gen_done, out_ready,
        input  cmd_busy, gen_start, gen_arg, gen_ready, out_valid, out_data,
               run_count, run_done, dbg_state
    );

    // Consumer side.
    modport slave (
        input  cmd_start, cmd_arg, gen_valid, gen_output, gen_done, out_ready,
        output cmd_busy, gen_start, gen_arg, gen_ready, out_valid, out_data,
               run_count, run_done, dbg_state
    );
endinterface

// File: rtl/gen_consumer.sv
// Generator consumer: starts one generator run per command, buffers the
// yielded values in a small FIFO and reports when the run has fully drained.
module gen_consumer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input logic           __clock,
    input logic           __reset,
    gen_consumer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] arg_q;
    logic [15:0]             run_count_q;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Backpressure is only released while a run is active and there is room.
    assign bus.gen_ready = (state == RUN) && !full;
    assign push          = bus.gen_valid && bus.gen_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.cmd_busy  = (state != IDLE);
    assign bus.gen_start = (state == START);
    assign bus.gen_arg   = arg_q;
    assign bus.run_count = run_count_q;
    assign bus.dbg_state = state;
    // Done is decoded in the DRAIN cycle that sees an empty FIFO, so a run
    // that ends with nothing buffered pulses in its first DRAIN cycle.
    assign bus.run_done  = (state == DRAIN) && empty;

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

    // Run sequencing, argument latch and yield counter.
    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            state       <= IDLE;
            arg_q       <= '0;
            run_count_q <= '0;
        end else begin
            if (push && (run_count_q != 16'hFFFF)) begin
                run_count_q <= run_count_q + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        arg_q       <= bus.cmd_arg;
                        run_count_q <= '0;
                        state       <= START;
                    end
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    // A done offered together with a value still lets the
                    // value be pushed above on the same edge.
                    if (bus.gen_done && bus.gen_ready) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; stale entries are never visible because out_data is masked when empty.
    always_ff @(posedge __clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.gen_output;
        end
    end
endmodule

// File: tb/tb_gen_consumer.sv
// Self-checking bench for gen_consumer: drives commands, models the generator,
// and checks the FIFO output stream against an expected-value queue.
module tb_gen_consumer;
    localparam int W = 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gen_consumer_if #(.WIDTH(W)) bus ();

    gen_consumer #(.DEPTH(4), .WIDTH(W)) dut (
        .__clock(clk),
        .__reset(rst),
        .bus    (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] gen_vals[$];
    int  rd_cnt;
    int  gs_cnt;
    int  push_cnt;
    bit  ov_seen;
    bit  rd_in_drain;
    bit  gen_abort;

    // Clock
    initial begin
        forever #5 clk = ~clk;
    end

    // Scoreboard and event monitor; samples on the falling edge.
    task automatic monitor();
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.run_done) begin
                    rd_cnt++;
                    if (bus.dbg_state == S_DRAIN) rd_in_drain = 1'b1;
                end
                if (bus.gen_start) gs_cnt++;
                if (bus.out_valid) ov_seen = 1'b1;
                if (bus.out_valid && bus.out_ready) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected got=%0d exp=<none>", $signed(bus.out_data));
                    end else begin
                        exp = exp_q.pop_front();
                        if (bus.out_data !== exp)
                            $display("FAIL sb_data got=%0d exp=%0d", $signed(bus.out_data), $signed(exp));
                        else n_pass++;
                    end
                end
                if (!bus.out_valid) begin
                    n_total++;
                    if (bus.out_data !== '0)
                        $display("FAIL out_data_idle got=%0h exp=0", bus.out_data);
                    else n_pass++;
                end
            end
        end
    endtask

    // Driver: issue one command; starts and ends just after a rising edge.
    task automatic send_cmd(input logic [W-1:0] arg);
        bus.cmd_start = 1'b1;
        bus.cmd_arg   = arg;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
    endtask

    // Generator model: waits for gen_start, then offers gen_vals in order and
    // finally done (together with the last value when coinc is set).
    task automatic gen_run(input bit coinc);
        int idx = 0;
        int n = gen_vals.size();
        int budget = 0;
        bit rdy;
        bit fin = 0;
        while (!bus.gen_start && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        n_total++;
        if (!bus.gen_start) begin
            $display("FAIL gen_start_timeout got=0 exp=1");
            return;
        end
        n_pass++;
        @(posedge clk); #1;
        budget = 0;
        while (!fin && !gen_abort && budget < 500) begin
            if (idx < n) begin
                bus.gen_valid  = 1'b1;
                bus.gen_output = gen_vals[idx];
                bus.gen_done   = coinc && (idx == n - 1);
            end else begin
                bus.gen_valid  = 1'b0;
                bus.gen_done   = 1'b1;
            end
            @(negedge clk);
            rdy = bus.gen_ready;
            @(posedge clk); #1;
            if (rdy) begin
                if (bus.gen_valid) begin
                    idx++;
                    push_cnt++;
                end
                if (bus.gen_done) fin = 1'b1;
            end
            budget++;
        end
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
        if (!gen_abort) begin
            n_total++;
            if (!fin) $display("FAIL gen_run_timeout got=%0d exp=%0d", idx, n);
            else n_pass++;
        end
    endtask

    // Wait until the consumer returns to IDLE, bounded.
    task automatic wait_idle(input string name);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (bus.cmd_busy && budget < 200);
        n_total++;
        if (bus.cmd_busy) $display("FAIL %s_idle_timeout got=busy exp=idle", name);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; gs_cnt = 0; push_cnt = 0;
        ov_seen = 1'b0; rd_in_drain = 1'b0; gen_abort = 1'b0;
        exp_q.delete();
        gen_vals.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_total++; if (bus.cmd_busy  !== 1'b0) $display("FAIL reset_cmd_busy got=%0b exp=0", bus.cmd_busy);  else n_pass++;
        n_total++; if (bus.gen_start !== 1'b0) $display("FAIL reset_gen_start got=%0b exp=0", bus.gen_start); else n_pass++;
        n_total++; if (bus.gen_ready !== 1'b0) $display("FAIL reset_gen_ready got=%0b exp=0", bus.gen_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data  !== '0)   $display("FAIL reset_out_data got=%0h exp=0", bus.out_data);   else n_pass++;
        n_total++; if (bus.run_done  !== 1'b0) $display("FAIL reset_run_done got=%0b exp=0", bus.run_done);   else n_pass++;
        n_total++; if (bus.run_count !== 16'd0) $display("FAIL reset_run_count got=%0d exp=0", bus.run_count); else n_pass++;
        n_total++; if (bus.gen_arg   !== '0)   $display("FAIL reset_gen_arg got=%0h exp=0", bus.gen_arg);     else n_pass++;
        n_total++; if (bus.dbg_state !== S_IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_stats();
        bus.out_ready = 1'b1;
        gen_vals = '{32'd1, 32'd1, 32'd3, 32'd5};
        exp_q    = '{32'd1, 32'd1, 32'd3, 32'd5};
        send_cmd(32'd10);
        gen_run(1'b0);
        wait_idle("basic");
        n_total++; if (bus.gen_arg !== 32'd10) $display("FAIL basic_gen_arg got=%0d exp=10", bus.gen_arg); else n_pass++;
        n_total++; if (bus.run_count !== 16'd4) $display("FAIL basic_run_count got=%0d exp=4", bus.run_count); else n_pass++;
        n_total++; if (rd_cnt != 1) $display("FAIL basic_run_done got=%0d exp=1", rd_cnt); else n_pass++;
        n_total++; if (gs_cnt != 1) $display("FAIL basic_gen_start got=%0d exp=1", gs_cnt); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL basic_left got=%0d exp=0", exp_q.size()); else n_pass++;
        n_total++; if (bus.cmd_busy !== 1'b0) $display("FAIL basic_busy got=%0b exp=0", bus.cmd_busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_stats();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gen_vals.push_back(W'($urandom_range(1000, 1)));
            exp_q.push_back(gen_vals[i]);
        end
        send_cmd(32'd6);
        fork
            gen_run(1'b0);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                n_total++; if (bus.gen_ready !== 1'b0) $display("FAIL bp_gen_ready got=%0b exp=0", bus.gen_ready); else n_pass++;
                n_total++; if (push_cnt != 4) $display("FAIL bp_pushes got=%0d exp=4", push_cnt); else n_pass++;
                n_total++; if (exp_q.size() != 6) $display("FAIL bp_popped got=%0d exp=6", exp_q.size()); else n_pass++;
                n_total++; if (bus.out_data !== gen_vals[0]) $display("FAIL bp_head got=%0d exp=%0d", bus.out_data, gen_vals[0]); else n_pass++;
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_idle("bp");
        n_total++; if (bus.run_count !== 16'd6) $display("FAIL bp_run_count got=%0d exp=6", bus.run_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL bp_left got=%0d exp=0", exp_q.size()); else n_pass++;
        n_total++; if (rd_cnt != 1) $display("FAIL bp_run_done got=%0d exp=1", rd_cnt); else n_pass++;
    endtask

    task automatic test_coincident();
        clear_stats();
        bus.out_ready = 1'b1;
        gen_vals = '{32'd7, 32'hFFFF_FFFB, 32'd9};
        exp_q    = '{32'd7, 32'hFFFF_FFFB, 32'd9};
        send_cmd(32'hFFFF_FFFF);
        gen_run(1'b1);
        wait_idle("coinc");
        n_total++; if (bus.run_count !== 16'd3) $display("FAIL coinc_run_count got=%0d exp=3", bus.run_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL coinc_left got=%0d exp=0", exp_q.size()); else n_pass++;
        n_total++; if (rd_cnt != 1) $display("FAIL coinc_run_done got=%0d exp=1", rd_cnt); else n_pass++;
        n_total++; if (bus.gen_arg !== 32'hFFFF_FFFF) $display("FAIL coinc_gen_arg got=%0h exp=ffffffff", bus.gen_arg); else n_pass++;
    endtask

    task automatic test_empty_run();
        clear_stats();
        bus.out_ready = 1'b1;
        send_cmd(32'd0);
        gen_run(1'b0);
        wait_idle("empty");
        n_total++; if (bus.run_count !== 16'd0) $display("FAIL empty_run_count got=%0d exp=0", bus.run_count); else n_pass++;
        n_total++; if (ov_seen) $display("FAIL empty_out_valid got=1 exp=0"); else n_pass++;
        n_total++; if (rd_cnt != 1) $display("FAIL empty_run_done got=%0d exp=1", rd_cnt); else n_pass++;
        n_total++; if (!rd_in_drain) $display("FAIL empty_done_in_drain got=0 exp=1"); else n_pass++;
    endtask

    task automatic test_ignored_cmd();
        clear_stats();
        bus.out_ready = 1'b1;
        gen_vals = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
        exp_q    = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
        send_cmd(32'd20);
        fork
            gen_run(1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.cmd_start = 1'b1;
                bus.cmd_arg   = 32'd99;
                @(posedge clk); #1;
                bus.cmd_start = 1'b0;
                @(negedge clk);
                n_total++; if (bus.gen_arg !== 32'd20) $display("FAIL ign_gen_arg got=%0d exp=20", bus.gen_arg); else n_pass++;
                n_total++; if (bus.dbg_state !== S_RUN) $display("FAIL ign_state got=%0d exp=%0d", bus.dbg_state, S_RUN); else n_pass++;
            end
        join
        wait_idle("ign");
        n_total++; if (gs_cnt != 1) $display("FAIL ign_gen_start got=%0d exp=1", gs_cnt); else n_pass++;
        n_total++; if (bus.run_count !== 16'd5) $display("FAIL ign_run_count got=%0d exp=5", bus.run_count); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.gen_arg !== 32'd20) $display("FAIL ign_hold_arg got=%0d exp=20", bus.gen_arg); else n_pass++;
        n_total++; if (bus.run_count !== 16'd5) $display("FAIL ign_hold_count got=%0d exp=5", bus.run_count); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int budget = 0;
        clear_stats();
        bus.out_ready = 1'b0;
        gen_vals = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
        send_cmd(32'd5);
        fork
            gen_run(1'b0);
            begin
                while (push_cnt < 2 && budget < 50) begin
                    @(posedge clk); #2;
                    budget++;
                end
                rst = 1'b1;
                #1;
                n_total++; if (bus.cmd_busy  !== 1'b0) $display("FAIL ar_cmd_busy got=%0b exp=0", bus.cmd_busy);   else n_pass++;
                n_total++; if (bus.out_valid !== 1'b0) $display("FAIL ar_out_valid got=%0b exp=0", bus.out_valid); else n_pass++;
                n_total++; if (bus.out_data  !== '0)   $display("FAIL ar_out_data got=%0h exp=0", bus.out_data);   else n_pass++;
                n_total++; if (bus.gen_ready !== 1'b0) $display("FAIL ar_gen_ready got=%0b exp=0", bus.gen_ready); else n_pass++;
                n_total++; if (bus.run_count !== 16'd0) $display("FAIL ar_run_count got=%0d exp=0", bus.run_count); else n_pass++;
                n_total++; if (bus.gen_arg   !== '0)   $display("FAIL ar_gen_arg got=%0h exp=0", bus.gen_arg);     else n_pass++;
                n_total++; if (bus.run_done  !== 1'b0) $display("FAIL ar_run_done got=%0b exp=0", bus.run_done);   else n_pass++;
                gen_abort = 1'b1;
            end
        join
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (rd_cnt != 0) $display("FAIL ar_no_run_done got=%0d exp=0", rd_cnt); else n_pass++;
        clear_stats();
        bus.out_ready = 1'b1;
        gen_vals = '{32'd3, 32'd4};
        exp_q    = '{32'd3, 32'd4};
        send_cmd(32'd2);
        gen_run(1'b0);
        wait_idle("ar_rerun");
        n_total++; if (bus.run_count !== 16'd2) $display("FAIL ar_rerun_count got=%0d exp=2", bus.run_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL ar_rerun_left got=%0d exp=0", exp_q.size()); else n_pass++;
        n_total++; if (rd_cnt != 1) $display("FAIL ar_rerun_done got=%0d exp=1", rd_cnt); else n_pass++;
    endtask

    // Test sequence and final report
    initial begin
        bus.cmd_start  = 1'b0;
        bus.cmd_arg    = '0;
        bus.gen_valid  = 1'b0;
        bus.gen_output = '0;
        bus.gen_done   = 1'b0;
        bus.out_ready  = 1'b0;
        clear_stats();
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_coincident();
        test_empty_run();
        test_ignored_cmd();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gen_consumer.md
GEN_CONSUMER -- requirements
Module: gen_consumer

Interface
REQ-001 Parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 Parameter WIDTH, default 32, meaning signed data width of argument and yielded values.
REQ-003 __clock  input  1  sole clock; all state updates on rising edge.
REQ-004 __reset  input  1  reset, asynchronous and active-high.
REQ-005 cmd_start  input  1  request one generator run using cmd_arg; honoured only in IDLE.
REQ-006 cmd_arg  input  WIDTH  signed argument for the run, sampled with cmd_start.
REQ-007 cmd_busy  output  1  high in every state except IDLE.
REQ-008 gen_start  output  1  drives generator __start; one-cycle pulse.
REQ-009 gen_arg  output  WIDTH  drives generator argument; holds latched cmd_arg.
REQ-010 gen_ready  output  1  drives generator __ready (backpressure).
REQ-011 gen_valid  input  1  generator __valid.
REQ-012 gen_output  input  WIDTH  generator __output_0.
REQ-013 gen_done  input  1  generator __done.
REQ-014 out_valid  output  1  FIFO head valid to downstream.
REQ-015 out_data  output  WIDTH  FIFO head value.
REQ-016 out_ready  input  1  downstream accepts head when high with out_valid.
REQ-017 run_count  output  16  yields captured in current or most recent run.
REQ-018 run_done  output  1  one-cycle pulse when a run has ended and FIFO has drained.

Function
REQ-019 FSM states IDLE, START, RUN, DRAIN; encoding free.
REQ-020 IDLE: cmd_start=1 -> latch cmd_arg into gen_arg, clear run_count to 0, go START; else stay.
REQ-021 START: gen_start=1 for exactly this cycle; next state RUN unconditionally.
REQ-022 gen_start SHALL be 0 in all states other than START.
REQ-023 RUN: gen_ready = FIFO not full (combinational from registered count); gen_ready=0 in IDLE, START, DRAIN.
REQ-024 Capture: gen_valid & gen_ready at rising edge -> push gen_output into FIFO, run_count+1, saturating at 16'hFFFF.
REQ-025 Termination: gen_done & gen_ready at rising edge in RUN -> go DRAIN; gen_done while gen_ready=0 is ignored.
REQ-026 gen_valid, gen_done and gen_ready all high same edge -> value captured and transition to DRAIN both occur.
REQ-027 DRAIN: when FIFO empty -> run_done=1 for one cycle, go IDLE; entering DRAIN with FIFO empty pulses run_done in the first DRAIN cycle.
REQ-028 cmd_start outside IDLE SHALL be ignored with no effect on state, gen_arg or run_count.
REQ-029 FIFO: out_valid = count!=0; out_data = head entry; pop on out_valid & out_ready.
REQ-030 Simultaneous push and pop SHALL leave count unchanged and preserve order; pop when empty and push when full are impossible by construction.
REQ-031 Full: gen_ready deasserts the cycle after the push that fills the FIFO; a pop reasserts it the cycle after the pop.
REQ-032 Pointers wrap modulo DEPTH; latency gen_output -> out_data is one cycle when FIFO was empty.
REQ-033 out_data SHALL be 0 when out_valid=0.
REQ-034 run_count and gen_arg hold their values in IDLE until the next accepted cmd_start.

Reset
REQ-035 Reset asserted -> immediately: state IDLE, FIFO empty, pointers 0, run_count 0, gen_arg 0.
REQ-036 Reset outputs: cmd_busy 0, gen_start 0, gen_ready 0, out_valid 0, out_data 0, run_done 0.
REQ-037 Reset mid-run (any state) SHALL discard FIFO contents and the run without emitting run_done.

Verification
REQ-038 Basic: cmd_arg=10, generator model yields 1,1,3,5 then done, out_ready=1 -> out_data sequence 1,1,3,5, run_count=4, single run_done pulse, cmd_busy 0 after.
REQ-039 Backpressure: DEPTH=4, out_ready=0, model yields 6 values -> gen_ready drops after 4 pushes, no value lost; out_ready=1 -> all 6 emerge in order.
REQ-040 Coincident: final value presented with gen_done and gen_valid same cycle -> value captured, run_count includes it, run_done follows drain.
REQ-041 Empty run: cmd_arg=0, model asserts gen_done immediately -> run_count=0, out_valid never high, run_done pulses one cycle into DRAIN.
REQ-042 Ignored command: cmd_start=1 with cmd_arg=99 during RUN -> gen_arg unchanged, no extra gen_start pulse.
REQ-043 Async reset in RUN with 2 entries buffered -> outputs at reset values before next clock edge, no run_done, next cmd_start runs normally.
